// File: rtl/chram_write_arbiter_pkg.sv
// Shared types and constants for the overlay character-RAM write arbiter.
package chram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int CHRAM_AW    = 12;
  localparam int CHRAM_DW    = 8;
  localparam int CHRAM_DEPTH = 2048;

  // Glyph codes written by the update engines
  localparam logic [7:0] WHEEL_A   = 8'h2A;
  localparam logic [7:0] WHEEL_B   = 8'h96;
  localparam logic [7:0] BAR_FULL  = 8'h7F;
  localparam logic [7:0] BAR_EMPTY = 8'hA6;

endpackage

// File: rtl/chram_write_arbiter_if.sv
// Requester beats, grant vector and RAM port-A write signals of the arbiter.
interface chram_arb_if
  import chram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = CHRAM_AW,
  parameter int DW = CHRAM_DW
);
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic [N-1:0]    gnt;
  logic            wr_ena;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            err;

  modport master (
    output req, last, addr, data,
    input  gnt, wr_ena, wr_addr, wr_data, err
  );

  modport slave (
    input  req, last, addr, data,
    output gnt, wr_ena, wr_addr, wr_data, err
  );
endinterface

// File: rtl/chram_write_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot pick of the first request at or after rr_ptr.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  sel
);
  logic [N-1:0] masked;
  logic         found;

  // Requests at or above the pointer win; otherwise wrap to the lowest index
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked[gi] = req[gi] && (PW'(gi) >= rr_ptr);
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chram_write_arbiter.sv
// Round-robin, burst-locking arbiter for the character RAM write port.
// Optional CHRAM_ARB_VBLANK_EN restricts grants and beat acceptance to the vblank window.
module chram_write_arbiter
  import chram_arb_pkg::*;
#(
  parameter int N         = 3,
  parameter int AW        = CHRAM_AW,
  parameter int DW        = CHRAM_DW,
  parameter int DEPTH     = CHRAM_DEPTH,
  parameter int MAX_BURST = 16
) (
  input  logic      i_clk,
  input  logic      reset,
  input  logic      vblank,
  chram_arb_if.slave bus
);
  localparam int          OW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  arb_state_t    state_reg, state_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [OW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]    beat_cnt_reg, beat_cnt_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic          wr_ena_reg, err_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [DW-1:0] wr_data_reg;

  logic [N-1:0]  pick_sel;
  logic [OW-1:0] pick_idx;
  logic          win_open, accept, in_range;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign addr_a[gi] = bus.addr[gi*AW +: AW];
    assign data_a[gi] = bus.data[gi*DW +: DW];
  end

`ifdef CHRAM_ARB_VBLANK_EN
  assign win_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign win_open      = 1'b1;
`endif

  rr_pick #(.N(N), .PW(OW)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .sel    (pick_sel)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_sel[i]) pick_idx = OW'(i);
    end
  end

  // A closed window stalls the owner without releasing it
  assign accept   = (state_reg == LOCK) && bus.req[owner_reg] && win_open;
  assign in_range = {1'b0, addr_a[owner_reg]} < DEPTH_V;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    gnt_next      = gnt_reg;
    case (state_reg)
      IDLE: begin
        if ((|bus.req) && win_open) begin
          gnt_next   = pick_sel;
          owner_next = pick_idx;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (!bus.req[owner_reg] ||
            (accept && (bus.last[owner_reg] || beat_cnt_reg == 8'(MAX_BURST - 1)))) begin
          state_next    = IDLE;
          gnt_next      = '0;
          beat_cnt_next = '0;
          rr_ptr_next   = (owner_reg == OW'(N - 1)) ? '0 : owner_reg + 1'b1;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      gnt_reg      <= '0;
      wr_ena_reg   <= 1'b0;
      err_reg      <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      gnt_reg      <= gnt_next;
      wr_ena_reg   <= accept && in_range;
      err_reg      <= accept && !in_range;
      if (accept && in_range) begin
        wr_addr_reg <= addr_a[owner_reg];
        wr_data_reg <= data_a[owner_reg];
      end
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.wr_ena  = wr_ena_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign bus.err     = err_reg;
endmodule

// File: tb/tb_chram_write_arbiter.sv
// Bench for chram_write_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_chram_write_arbiter;
  import chram_arb_pkg::*;

  localparam int N = 3, AW = 12, DW = 8, DEPTH = 2048, MAXB = 16;

  logic i_clk  = 1'b0;
  logic reset  = 1'b1;
  logic vblank = 1'b1;
  always #5 i_clk = ~i_clk;

  chram_arb_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  chram_write_arbiter #(.N(N), .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .i_clk  (i_clk),
    .reset  (reset),
    .vblank (vblank),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: owner (-1 when free), beats in current grant, next-turn pointer
  int            m_owner = -1, m_beats = 0, m_ptr = 0;
  logic [N-1:0]  m_gnt = '0;
  logic          m_wr_ena = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  int            glog[$];

  // Requester driver state
  int            rem[N];
  int            nolast[N];
  logic [AW-1:0] baddr[N];
  int            rnd_addr = 0, drop_rate = 0;

  int            n_wr = 0, n_err = 0;
  logic [N-1:0]  ghist[$];
  logic [N-1:0]  exp_g2 [9] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic win_now();
`ifdef CHRAM_ARB_VBLANK_EN
    return vblank;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int glog_at(int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  task automatic set_lane(int k, logic r, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [N-1:0]    m;
    logic [N*AW-1:0] am;
    logic [N*DW-1:0] dm;
    m        = N'(1) << k;
    bus.req  = r ? (bus.req | m) : (bus.req & ~m);
    bus.last = l ? (bus.last | m) : (bus.last & ~m);
    am       = (N*AW)'({AW{1'b1}}) << (k*AW);
    dm       = (N*DW)'({DW{1'b1}}) << (k*DW);
    bus.addr = (bus.addr & ~am) | ((N*AW)'(a) << (k*AW));
    bus.data = (bus.data & ~dm) | ((N*DW)'(d) << (k*DW));
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.last = '0; bus.addr = '0; bus.data = '0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; nolast[k] = 0; baddr[k] = '0; end
  endtask

  task automatic drive();
    logic dropit;
    for (int k = 0; k < N; k++) begin
      dropit = (drop_rate != 0) && (|(bus.gnt & (N'(1) << k))) &&
               ($urandom_range(drop_rate - 1) == 0);
      set_lane(k, (rem[k] > 0) && !dropit, (rem[k] == 1) && (nolast[k] == 0),
               (rnd_addr != 0) ? AW'($urandom_range(2100)) : baddr[k], DW'($urandom));
    end
  endtask

  task automatic m_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_beats = 0;
  endtask

  // Predict the registered outputs after the coming edge from the visible inputs
  task automatic model_edge();
    logic [AW-1:0] a;
    logic          rq, lst;
    m_wr_ena = 1'b0;
    m_err    = 1'b0;
    if (reset) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_wr_addr = '0; m_wr_data = '0;
    end else if (m_owner < 0) begin
      if (bus.req != '0 && win_now()) begin
        for (int i = 0; i < N; i++)
          if (m_owner < 0 && |(bus.req & (N'(1) << ((m_ptr + i) % N)))) m_owner = (m_ptr + i) % N;
        glog.push_back(m_owner);
      end
    end else begin
      rq  = |(bus.req & (N'(1) << m_owner));
      lst = |(bus.last & (N'(1) << m_owner));
      if (!rq) m_release();
      else if (win_now()) begin
        a = AW'(bus.addr >> (m_owner*AW));
        m_beats++;
        if (a < DEPTH) begin
          m_wr_ena = 1'b1; m_wr_addr = a; m_wr_data = DW'(bus.data >> (m_owner*DW));
        end else m_err = 1'b1;
        if (lst || m_beats == MAXB) m_release();
      end
    end
    m_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endtask

  task automatic cycle();
    logic [N-1:0] g_pre, r_pre;
    logic         w_pre, rst_pre;
    g_pre = bus.gnt; r_pre = bus.req; w_pre = win_now(); rst_pre = reset;
    model_edge();
    @(posedge i_clk); #1;
    for (int k = 0; k < N; k++)
      if (!rst_pre && w_pre && rem[k] > 0 && |(g_pre & r_pre & (N'(1) << k))) begin
        rem[k]--; baddr[k]++;
      end
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("wr_ena", 32'(bus.wr_ena), 32'(m_wr_ena));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
    chk("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
    if (bus.wr_ena) n_wr++;
    if (bus.err) n_err++;
    ghist.push_back(bus.gnt);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin drive(); cycle(); end
  endtask

  initial begin
    int idx, len;
    clear_inputs();

    // Reset state
    reset = 1'b1; cycle(); cycle();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_wr_ena", 32'(bus.wr_ena), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0; cycle();

    // Single requester, 3-beat progress-bar burst
    set_lane(0, 1, 0, 136, BAR_FULL); cycle();
    chk("t1_gnt", 32'(bus.gnt), 32'b001);
    chk("t1_no_wr_yet", 32'(bus.wr_ena), 32'd0);
    cycle();
    chk("t1_wr0_ena", 32'(bus.wr_ena), 32'd1);
    chk("t1_wr0_addr", 32'(bus.wr_addr), 32'd136);
    set_lane(0, 1, 0, 137, BAR_FULL); cycle();
    chk("t1_wr1_addr", 32'(bus.wr_addr), 32'd137);
    set_lane(0, 1, 1, 138, BAR_EMPTY); cycle();
    chk("t1_wr2_addr", 32'(bus.wr_addr), 32'd138);
    chk("t1_wr2_data", 32'(bus.wr_data), 32'hA6);
    chk("t1_gnt_released", 32'(bus.gnt), 32'd0);
    set_lane(0, 0, 0, 0, 0); cycle();
    chk("t1_wr_done", 32'(bus.wr_ena), 32'd0);

    // Pointer moved to 1; then owner abort
    set_lane(0, 1, 0, 100, 8'h55); set_lane(1, 1, 0, 200, WHEEL_A); cycle();
    chk("t1b_gnt_ptr1", 32'(bus.gnt), 32'b010);
    cycle();
    chk("t1b_wr_addr", 32'(bus.wr_addr), 32'd200);
    set_lane(1, 0, 0, 201, WHEEL_B); cycle();
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_no_wr", 32'(bus.wr_ena), 32'd0);
    cycle();
    chk("t1b_gnt_wrap", 32'(bus.gnt), 32'b001);
    set_lane(0, 0, 0, 0, 0); cycle();
    chk("abort0_gnt", 32'(bus.gnt), 32'd0);
    chk("abort0_no_wr", 32'(bus.wr_ena), 32'd0);
    cycle();

    // Three-way contention from reset, 2-beat bursts
    reset = 1'b1; clear_inputs(); cycle(); reset = 1'b0;
    rem[0] = 2; rem[1] = 2; rem[2] = 2; baddr[0] = 10; baddr[1] = 20; baddr[2] = 30;
    ghist.delete(); glog.delete(); n_wr = 0;
    run(12);
    for (int i = 0; i < 9; i++) chk("t2_gnt_seq", 32'(ghist[i]), 32'(exp_g2[i]));
    chk("t2_order0", glog_at(0), 0);
    chk("t2_order1", glog_at(1), 1);
    chk("t2_order2", glog_at(2), 2);
    chk("t2_writes", n_wr, 6);

    // Fairness limit: 20 beats without last against a pending requester
    ghist.delete(); glog.delete(); n_wr = 0;
    rem[1] = 20; nolast[1] = 1; baddr[1] = 300;
    run(1);
    rem[2] = 2; baddr[2] = 400;
    run(40);
    idx = 0; len = 0;
    while (idx < ghist.size() && ghist[idx] == 3'b010) begin len++; idx++; end
    chk("t3_burst_len", len, MAXB);
    while (idx < ghist.size() && ghist[idx] == 3'b000) idx++;
    chk("t3_next_gnt", (idx < ghist.size()) ? 32'(ghist[idx]) : 32'd0, 32'b100);
    chk("t3_order0", glog_at(0), 1);
    chk("t3_order1", glog_at(1), 2);
    chk("t3_order2", glog_at(2), 1);
    chk("t3_writes", n_wr, 22);
    nolast[1] = 0;

    // Address boundary: 2047 written, 2048 rejected with err
    n_wr = 0; n_err = 0; rem[0] = 2; baddr[0] = 2047;
    run(8);
    chk("t4_writes", n_wr, 1);
    chk("t4_err_pulses", n_err, 1);
    chk("t4_hold_addr", 32'(bus.wr_addr), 32'd2047);

    // Reset during the second beat of a 4-beat burst
    n_wr = 0; rem[1] = 4; baddr[1] = 500;
    run(2);
    drive(); reset = 1'b1; cycle();
    chk("t5_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_wr_ena", 32'(bus.wr_ena), 32'd0);
    chk("t5_writes", n_wr, 1);
    reset = 1'b0; clear_inputs(); glog.delete();
    rem[0] = 1; rem[2] = 1; baddr[0] = 600; baddr[2] = 700;
    run(8);
    chk("t5_first_after_rst", glog_at(0), 0);
    chk("t5_req2_granted", glog_at(1), 2);

`ifdef CHRAM_ARB_VBLANK_EN
    // Grants and beats only inside the blank window
    vblank = 1'b0; rem[0] = 3; baddr[0] = 50;
    run(3);
    chk("vb_no_gnt", 32'(bus.gnt), 32'd0);
    vblank = 1'b1; run(1);
    chk("vb_gnt", 32'(bus.gnt), 32'b001);
    run(1);
    chk("vb_beat1", 32'(bus.wr_ena), 32'd1);
    vblank = 1'b0; run(2);
    chk("vb_stall_gnt", 32'(bus.gnt), 32'b001);
    chk("vb_stall_wr", 32'(bus.wr_ena), 32'd0);
    vblank = 1'b1; run(1);
    chk("vb_resume", 32'(bus.wr_ena), 32'd1);
    run(4);
`endif

    // Random traffic: bursts of random length, lost lasts, aborts, out-of-range addresses
    rnd_addr = 1; drop_rate = 20;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++)
        if (rem[k] == 0 && $urandom_range(3) == 0) begin
          rem[k]    = $urandom_range(24, 1);
          nolast[k] = ($urandom_range(4) == 0) ? 1 : 0;
        end
`ifdef CHRAM_ARB_VBLANK_EN
      vblank = ($urandom_range(3) != 0);
`else
      vblank = 1'($urandom);
`endif
      drive(); cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
